// File: rtl/bus_pkg.sv
// Shared definitions for the RAM/IO bus arbiter: FSM states, region codes and
// default bus widths.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_e;

   // Address regions selected by the two top address bits
   localparam logic [1:0] REG_IO  = 2'd0;
   localparam logic [1:0] REG_RAM = 2'd1;
   localparam logic [1:0] REG_2   = 2'd2;
   localparam logic [1:0] REG_3   = 2'd3;

   localparam int DEF_AW = 16;
   localparam int DEF_DW = 16;

   // One-hot chip select for a region code; all four regions are legal
   function automatic logic [3:0] region_cs(input logic [1:0] region);
      logic [3:0] cs;
      case (region)
         REG_IO:  cs = 4'b0001;
         REG_RAM: cs = 4'b0010;
         REG_2:   cs = 4'b0100;
         REG_3:   cs = 4'b1000;
         default: cs = 4'b0000;
      endcase
      return cs;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester searching upward from
// ptr_i+1, wrapping modulo NREQ. ptr_i itself is considered last.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [IW-1:0]   win_o,
   output logic            vld_o
);

   // Scan from farthest to nearest so the nearest requester overwrites last
   always_comb begin
      win_o = '0;
      vld_o = 1'b0;
      for (int i = NREQ; i >= 1; i--) begin
         int idx;
         idx = (int'(ptr_i) + i) % NREQ;
         if (req_i[idx]) begin
            win_o = IW'(idx);
            vld_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing the 16-bit RAM/IO bus between NREQ masters.
// Each access is a two-cycle ACCESS/COMPLETE transaction; lock bursts let an
// owner keep the bus for up to MAX_HOLD accesses while others wait.
module ram_bus_arbiter
   import bus_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ-1:0]    wr_in,
   input  logic [NREQ*AW-1:0] addr_in,
   input  logic [NREQ*DW-1:0] wdata_in,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      bus_addr,
   output logic [DW-1:0]      bus_wdata,
   output logic               bus_write,
   input  logic [DW-1:0]      bus_rdata,
   output logic [3:0]         cs,
   output logic               busy
);

   localparam int IW = $clog2(NREQ);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [HW-1:0]   hold_q, hold_d;

   logic [IW-1:0]   pick_ptr;
   logic [IW-1:0]   pick_win;
   logic            pick_vld;
   logic [NREQ-1:0] owner_oh;
   logic            others_pending;
   logic [AW-1:0]   sel_addr;

   assign owner_oh       = NREQ'(1) << owner_q;
   assign others_pending = |(req & ~owner_oh);
   // Leaving COMPLETE the old owner becomes the pointer, so it is picked last
   assign pick_ptr       = (state_q == COMPLETE) ? owner_q : rr_ptr_q;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req_i (req),
      .ptr_i (pick_ptr),
      .win_o (pick_win),
      .vld_o (pick_vld)
   );

   // State, owner, round-robin pointer and lock-hold counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= IW'(NREQ - 1);
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         hold_q   <= hold_d;
      end
   end

   // Next-state logic: arbitration in IDLE, lock continuation or re-arbitration after COMPLETE
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = ACCESS;
               owner_d = pick_win;
               hold_d  = '0;
            end
         end
         ACCESS: state_d = COMPLETE;
         COMPLETE: begin
            if (lock[owner_q] && req[owner_q] &&
                ((hold_q < HOLD_LAST) || !others_pending)) begin
               state_d = ACCESS;
               if (hold_q < HOLD_LAST) hold_d = hold_q + HW'(1);
            end else if (pick_vld) begin
               state_d  = ACCESS;
               owner_d  = pick_win;
               rr_ptr_d = owner_q;
               hold_d   = '0;
            end else begin
               state_d  = IDLE;
               rr_ptr_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs decoded from the registered state so reset clears them at once
   always_comb begin
      gnt       = '0;
      ack       = '0;
      rdata     = '0;
      bus_addr  = '0;
      bus_wdata = '0;
      bus_write = 1'b0;
      cs        = '0;
      busy      = 1'b0;
      sel_addr  = addr_in[int'(owner_q)*AW +: AW];
      if (state_q == ACCESS || state_q == COMPLETE) begin
         gnt       = owner_oh;
         busy      = 1'b1;
         bus_addr  = sel_addr;
         bus_wdata = wdata_in[int'(owner_q)*DW +: DW];
         cs        = region_cs(sel_addr[AW-1 -: 2]);
         if (state_q == ACCESS) begin
            bus_write = wr_in[owner_q];
         end else begin
            ack   = owner_oh;
            rdata = bus_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter (NREQ=2, MAX_HOLD=8).
module tb_ram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, lock, wr_in;
   logic [31:0] addr_in, wdata_in;
   logic [1:0]  gnt, ack;
   logic [15:0] rdata, bus_addr, bus_wdata, bus_rdata;
   logic        bus_write, busy;
   logic [3:0]  cs;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_bus_arbiter #(.NREQ(2), .AW(16), .DW(16), .MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .wr_in     (wr_in),
      .addr_in   (addr_in),
      .wdata_in  (wdata_in),
      .gnt       (gnt),
      .ack       (ack),
      .rdata     (rdata),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_write (bus_write),
      .bus_rdata (bus_rdata),
      .cs        (cs),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle past the edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".gnt"},   32'(gnt), 32'h0);
      chk({tag, ".ack"},   32'(ack), 32'h0);
      chk({tag, ".busy"},  32'(busy), 32'h0);
      chk({tag, ".addr"},  32'(bus_addr), 32'h0);
      chk({tag, ".wdata"}, 32'(bus_wdata), 32'h0);
      chk({tag, ".cs"},    32'(cs), 32'h0);
      chk({tag, ".rdata"}, 32'(rdata), 32'h0);
      chk({tag, ".wr"},    32'(bus_write), 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; lock = '0; wr_in = '0;
      addr_in = '0; wdata_in = '0; bus_rdata = 16'hBEEF;
      #12;
      addr_in  = 32'h1234_5678;
      wdata_in = 32'h9ABC_DEF0;
      #1;
      chk_idle("reset");
      rst_n = 1'b1;
      step();
      chk_idle("idle_noreq");

      // Single read by master 0
      req = 2'b01; wr_in = 2'b00; addr_in = {16'h0000, 16'h4010};
      step();
      chk("rd.acc.gnt",  32'(gnt), 32'h1);
      chk("rd.acc.cs",   32'(cs), 32'h2);
      chk("rd.acc.addr", 32'(bus_addr), 32'h4010);
      chk("rd.acc.ack",  32'(ack), 32'h0);
      chk("rd.acc.busy", 32'(busy), 32'h1);
      step();
      chk("rd.cmp.ack",   32'(ack), 32'h1);
      chk("rd.cmp.rdata", 32'(rdata), 32'hBEEF);
      chk("rd.cmp.gnt",   32'(gnt), 32'h1);
      req = 2'b00;
      step();
      chk_idle("rd.after");

      // Write to IO by master 1
      req = 2'b10; wr_in = 2'b10; addr_in = {16'h0003, 16'h4010};
      wdata_in = {16'h00A5, 16'h1111};
      step();
      chk("wr.acc.gnt",   32'(gnt), 32'h2);
      chk("wr.acc.write", 32'(bus_write), 32'h1);
      chk("wr.acc.cs",    32'(cs), 32'h1);
      chk("wr.acc.wdata", 32'(bus_wdata), 32'h00A5);
      chk("wr.acc.addr",  32'(bus_addr), 32'h0003);
      step();
      chk("wr.cmp.write", 32'(bus_write), 32'h0);
      chk("wr.cmp.ack",   32'(ack), 32'h2);
      chk("wr.cmp.cs",    32'(cs), 32'h1);
      req = 2'b00; wr_in = 2'b00;
      step();
      chk_idle("wr.after");

      // Contention without lock: alternate 0,1,0,1 from reset
      do_reset();
      req = 2'b11; addr_in = {16'hC000, 16'h8000};
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rr%0d.gnt", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("rr%0d.cs", k),  32'(cs),  (k % 2 == 0) ? 32'h4 : 32'h8);
         chk($sformatf("rr%0d.ack0", k), 32'(ack), 32'h0);
         step();
         chk($sformatf("rr%0d.ack", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      end
      req = 2'b00;
      step();
      chk("rr.idle.busy", 32'(busy), 32'h0);

      // Lock cap: master 0 gets exactly 8 accesses, then master 1
      do_reset();
      req = 2'b11; lock = 2'b01;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("lk%0d.gnt", k), 32'(gnt), 32'h1);
         step();
         chk($sformatf("lk%0d.ack", k), 32'(ack), 32'h1);
      end
      step();
      chk("lk.cap.gnt", 32'(gnt), 32'h2);
      step();
      chk("lk.cap.ack", 32'(ack), 32'h2);
      // With master 1 quiet, master 0 keeps the bus past the cap
      req = 2'b01;
      for (int k = 0; k < 12; k++) begin
         step();
         chk($sformatf("lkh%0d.gnt", k), 32'(gnt), 32'h1);
         step();
         chk($sformatf("lkh%0d.ack", k), 32'(ack), 32'h1);
      end
      req = 2'b00; lock = 2'b00;
      step();
      chk("lk.idle.busy", 32'(busy), 32'h0);

      // Reset during a write access
      req = 2'b01; wr_in = 2'b01; addr_in = {16'h0000, 16'h4020};
      step();
      chk("rst.acc.write", 32'(bus_write), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst.async.write", 32'(bus_write), 32'h0);
      chk("rst.async.gnt",   32'(gnt), 32'h0);
      chk("rst.async.cs",    32'(cs), 32'h0);
      chk("rst.async.busy",  32'(busy), 32'h0);
      step();
      chk("rst.noack", 32'(ack), 32'h0);
      req = 2'b11; wr_in = 2'b00;
      rst_n = 1'b1;
      step();
      chk("rst.first.gnt", 32'(gnt), 32'h1);
      step();
      chk("rst.first.ack", 32'(ack), 32'h1);
      req = 2'b00;
      step();
      chk("rst.idle.busy", 32'(busy), 32'h0);

      // Master drops req during ACCESS: transaction still completes
      req = 2'b01; bus_rdata = 16'h5A5A;
      step();
      chk("drop.acc.gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      step();
      chk("drop.cmp.ack",   32'(ack), 32'h1);
      chk("drop.cmp.rdata", 32'(rdata), 32'h5A5A);
      step();
      chk("drop.idle.busy", 32'(busy), 32'h0);
      chk("drop.idle.gnt",  32'(gnt), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single 16-bit data bus (RAM, IO and spare regions) between NREQ bus masters, e.g. the CPU5_9 data port and a DMA/loader engine.
- Performs round-robin arbitration with optional lock bursts, drives the shared address/data/write lines, and decodes the 4 one-hot chip selects from addr[15:14].
- Sequences each access as a two-cycle transaction matched to the synchronous RAM/IO read timing.
- Sits between the masters and the RAM/IO slaves on clk_out.

Parameters:
- NREQ, 2, number of requesting masters (2..4).
- AW, 16, address width.
- DW, 16, data width.
- MAX_HOLD, 8, maximum consecutive locked accesses by one owner while another request is pending.

Ports:
- clk  input  1  bus clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- req  input  NREQ  per-master access request.
- lock  input  NREQ  per-master burst-lock hint.
- wr_in  input  NREQ  per-master write enable (1 = write).
- addr_in  input  NREQ*AW  packed per-master address; master i at [i*AW +: AW].
- wdata_in  input  NREQ*DW  packed per-master write data.
- gnt  output  NREQ  one-hot; marks the current owner.
- ack  output  NREQ  one-hot completion pulse to the owner.
- rdata  output  DW  read data; valid only while the owner's ack is high.
- bus_addr  output  AW  shared bus address.
- bus_wdata  output  DW  shared bus write data.
- bus_write  output  1  shared write strobe.
- bus_rdata  input  DW  slave read data; mux of the RAM/IO outputs.
- cs  output  4  one-hot region select = 1 << bus_addr[15:14].
- busy  output  1  high while a transaction is in progress.

Behaviour:
- States: IDLE, ACCESS, COMPLETE. The state, the owner index, rr_ptr (last owner) and hold_cnt are registered.
- Reset (async, rst_n=0): state=IDLE, owner=0, rr_ptr=NREQ-1 so master 0 wins first, hold_cnt=0. All outputs are 0: gnt, ack, rdata, bus_addr, bus_wdata, bus_write, cs, busy.
- Reset asserted mid-transaction aborts it immediately: no ack, and any bus_write drops asynchronously.
- IDLE: if any req is high, the winner is the first requester searching from rr_ptr+1 upward with wrap modulo NREQ. Next state is ACCESS with owner=winner and hold_cnt=0. Otherwise IDLE is held.
- ACCESS (1 cycle):
  - gnt[owner]=1.
  - bus_addr, bus_wdata and bus_write are combinationally muxed from the owner's addr_in, wdata_in and wr_in.
  - cs is decoded from bus_addr; busy=1.
  - Next state is COMPLETE unconditionally. The owner's req is not re-checked, so there is no abort.
- COMPLETE (1 cycle):
  - gnt[owner]=1; bus_addr and cs stay driven from the owner; bus_write=0; busy=1.
  - ack[owner]=1 and rdata=bus_rdata (the synchronous slave output); ack and rdata are also valid for writes.
  - req sampled at the end of COMPLETE is a new request. A master wanting only one access drops req in its ack cycle.
- Leaving COMPLETE, in priority order:
  - (a) lock[owner] and req[owner] are high, and either hold_cnt<MAX_HOLD-1 or no other req is pending: ACCESS, same owner, hold_cnt+1 (saturating).
  - (b) else, if any req is pending: ACCESS with the round-robin winner, rr_ptr=owner, hold_cnt=0. The previous owner is eligible only if no other master requests.
  - (c) else: IDLE, rr_ptr=owner.
- Latency: req rising while IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2. Back-to-back throughput is one access per 2 cycles, with no dead cycle.
- Simultaneous requests from IDLE go to round-robin order; the same rule applies leaving COMPLETE.
- Outside ACCESS/COMPLETE: gnt=0, cs=0, bus_write=0, rdata=0, and bus_addr/bus_wdata=0.
- cs decode covers all 4 regions; regions 2/3 are legal with no error flag.
- Width rules: no arithmetic on data. The owner index is clog2(NREQ) bits and pointer wrap is modulo NREQ.

Decomposition:
- Shared package `bus_pkg`:
  - state enum {IDLE, ACCESS, COMPLETE};
  - region constants REG_IO=0, REG_RAM=1, REG_2=2, REG_3=3;
  - default AW/DW.
- One sub-module, `rr_pick`: combinational round-robin picker taking (req, rr_ptr) and returning winner index and valid.
- The FSM, hold counter and bus muxes stay in ram_bus_arbiter.

Test Plan:
- Single read: after reset, req[0]=1, wr_in[0]=0, addr_in0=16'h4010, slave returns 16'hBEEF.
  - Cycle 1: gnt=01, cs=0010, bus_addr=4010.
  - Cycle 2: ack=01, rdata=BEEF. The bus then returns to IDLE with all outputs 0.
- Write to IO: req[1]=1, wr_in[1]=1, addr_in1=16'h0003, wdata_in1=16'h00A5.
  - ACCESS: bus_write=1, cs=0001, bus_wdata=00A5.
  - COMPLETE: bus_write=0, ack=10.
- Contention: req=11 held continuously, no lock, from reset. Grant order is 0,1,0,1 and ack pulses every 2 cycles alternating.
- Lock cap: MAX_HOLD=8, lock[0]=req[0]=1, req[1]=1.
  - Master 0 gets exactly 8 consecutive accesses, then master 1 is granted.
  - With req[1]=0, master 0 keeps the bus indefinitely.
- Reset mid-access: assert rst_n=0 during ACCESS with wr_in=1.
  - bus_write, gnt and cs drop to 0 immediately and no ack is seen.
  - After release, master 0 wins first.
- Late request drop: master 0 deasserts req during ACCESS. COMPLETE and ack still occur, then the block goes to IDLE.
